// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings, FSM states and ALU control shared by the multicycle core
package mips_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
  function automatic alu_op_t alu_ctl(logic [5:0] op, logic [5:0] funct);
    return op != OP_R ? ALU_ADD : funct == F_SUB ? ALU_SUB : funct == F_AND ? ALU_AND :
           funct == F_OR ? ALU_OR : funct == F_SLT ? ALU_SLT : ALU_ADD;
  endfunction
  // halt and every unknown encoding fall out as invalid; R-type also needs shamt=0
  function automatic logic is_valid(logic [31:0] ir);
    return ir[31:26] == OP_R ? (ir[10:6] == 5'd0 && ir[5:0] inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT})
                             : ir[31:26] inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
  endfunction
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32 x XLEN register file, two async read ports, one sync write port, r0 reads 0
// Ports: clk, rst (sync, clears all), ra1/ra2 -> rd1/rd2, we/wa/wd write port
module mips_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  logic [XLEN-1:0] regs [32];
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0)
      regs[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : regs[ra2];
endmodule

// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS subset core (add sub and or slt addi lw sw beq j halt)
// Ports: clk, rst (sync active-high); mem_req/mem_we/mem_addr/mem_wdata request, held until mem_ack;
//        mem_rdata fetch/load data; halted, pc_o, retired debug outputs.
// Macro MIPS_MC_PERF_EN: enables the retired-instruction counter, otherwise retired is tied to 0.
module mips_multicycle import mips_pkg::*; #(
  parameter int XLEN = 32,
  parameter int AW = 10,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_ack,
  output logic            halted,
  output logic [AW-1:0]   pc_o,
  output logic [31:0]     retired
);
  state_t state;
  alu_op_t alu_op;
  logic [31:0] ir;
  logic [AW-1:0] pc, pc4, br_pc, j_pc, nxt_pc, d_addr;
  logic [XLEN-1:0] a, b, alu_out, mdr, rd1, rd2, imm, src_b, alu_res, wd;
  logic [5:0] op;
  logic [4:0] wa;
  logic valid;
  assign op = ir[31:26];
  assign valid = is_valid(ir);
  assign alu_op = alu_ctl(op, ir[5:0]);
  assign imm = XLEN'($signed(ir[15:0]));
  assign src_b = op == OP_R ? b : imm;
  assign alu_res = alu_op == ALU_SUB ? a - src_b : alu_op == ALU_AND ? a & src_b :
                   alu_op == ALU_OR ? a | src_b : alu_op == ALU_SLT ? XLEN'($signed(a) < $signed(src_b)) :
                   a + src_b;
  assign pc4 = pc + AW'(4);
  assign br_pc = pc4 + (AW'(imm) << 2);
  // jump keeps any PC bits above bit 27 and replaces the rest with target<<2
  assign j_pc = (pc & ~AW'(28'hFFF_FFFF)) | AW'({ir[25:0], 2'b00});
  assign nxt_pc = op == OP_J ? j_pc : a == b ? br_pc : pc4;
  assign d_addr = AW'(alu_res) & ~AW'(3);
  assign wa = op == OP_R ? ir[15:11] : ir[20:16];
  assign wd = op == OP_LW ? mdr : alu_out;
  assign pc_o = pc;
  mips_regfile #(.XLEN(XLEN)) u_rf (
    .clk(clk), .rst(rst), .ra1(ir[25:21]), .ra2(ir[20:16]), .rd1(rd1), .rd2(rd2),
    .we(state == WB), .wa(wa), .wd(wd)
  );
  // transitions into FETCH raise the request directly so a fetch takes one cycle with an
  // immediate ack; only the first fetch after reset spends a cycle raising mem_req
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= RESET_PC;
      mem_wdata <= '0;
      halted <= 1'b0;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      mdr <= '0;
    end else begin
      case (state)
        FETCH:
          if (!mem_req) begin
            mem_req <= 1'b1;
            mem_addr <= pc;
          end else if (mem_ack) begin
            ir <= mem_rdata;
            mem_req <= 1'b0;
            state <= DECODE;
          end
        DECODE: begin
          a <= rd1;
          b <= rd2;
          halted <= !valid;
          state <= valid ? EXEC : HALT;
        end
        EXEC: begin
          alu_out <= alu_res;
          if (op == OP_BEQ || op == OP_J) begin
            pc <= nxt_pc;
            mem_addr <= nxt_pc;
            mem_req <= 1'b1;
            state <= FETCH;
          end else if (op == OP_LW || op == OP_SW) begin
            mem_req <= 1'b1;
            mem_we <= op == OP_SW;
            mem_addr <= d_addr;
            mem_wdata <= b;
            state <= MEM;
          end else begin
            state <= WB;
          end
        end
        MEM:
          if (mem_ack) begin
            mdr <= mem_rdata[XLEN-1:0];
            mem_we <= 1'b0;
            mem_req <= op == OP_SW;
            mem_addr <= pc4;
            pc <= op == OP_SW ? pc4 : pc;
            state <= op == OP_SW ? FETCH : WB;
          end
        WB: begin
          pc <= pc4;
          mem_addr <= pc4;
          mem_req <= 1'b1;
          state <= FETCH;
        end
        default: begin
          halted <= 1'b1;
          mem_req <= 1'b0;
          state <= HALT;
        end
      endcase
    end
  end
`ifdef MIPS_MC_PERF_EN
  logic [31:0] perf_cnt;
  logic done;
  assign done = state == WB || (state == MEM && mem_ack && op == OP_SW) ||
                (state == EXEC && (op == OP_BEQ || op == OP_J));
  always_ff @(posedge clk)
    if (rst) perf_cnt <= '0;
    else if (done) perf_cnt <= perf_cnt + 32'd1;
  assign retired = perf_cnt;
`else
  assign retired = '0;
`endif
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed self-checking bench for the multicycle MIPS core (32-bit and 16-bit builds)
module tb_mips_multicycle;
`ifdef MIPS_MC_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    logic [9:0]  a;
    logic        we;
    logic [31:0] d;
    int          len;
    int          t;
  } acc_t;
  logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
  logic mem_req, mem_we, mem_ack = 1'b0, halted;
  logic [9:0] mem_addr, pc_o;
  logic [31:0] mem_wdata, mem_rdata = '0, retired;
  logic mem_req2, mem_we2, mem_ack2 = 1'b0, halted2;
  logic [7:0] mem_addr2, pc_o2;
  logic [15:0] mem_wdata2;
  logic [31:0] mem_rdata2 = '0, retired2;
  logic [31:0] mem [256];
  logic [31:0] mem2 [64];
  acc_t log_q[$];
  int ack_dly = 0, cnt = 0, cyc = 0, checks = 0, errors = 0;

  mips_multicycle #(.XLEN(32), .AW(10), .RESET_PC(10'h0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted),
    .pc_o(pc_o), .retired(retired)
  );
  mips_multicycle #(.XLEN(16), .AW(8), .RESET_PC(8'h20)) dut16 (
    .clk(clk), .rst(rst2), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ack(mem_ack2), .halted(halted2),
    .pc_o(pc_o2), .retired(retired2)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // memory for the 32-bit core: ack comes ack_dly cycles after the first request cycle
  initial forever begin
    @(negedge clk);
    if (mem_req) begin
      if (cnt >= ack_dly) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        log_q.push_back('{a: mem_addr, we: mem_we, d: mem_wdata, len: cnt + 1, t: cyc - cnt});
        cnt = 0;
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      cnt = 0;
    end
  end

  // memory for the 16-bit core: acks in the first request cycle
  initial forever begin
    @(negedge clk);
    mem_ack2 = mem_req2;
    if (mem_req2) begin
      mem_rdata2 = mem2[mem_addr2[7:2]];
      if (mem_we2) mem2[mem_addr2[7:2]] = {16'h0, mem_wdata2};
    end
  end

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] f);
    return {6'h00, rs, rt, rd, 5'd0, f};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = (i >= 16 && i < 48) ? 32'hDEADBEEF : 32'h0;
    log_q.delete();
  endtask
  task automatic reset_hold();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wait_halt(input int max, input string tag);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    int n;
    // arithmetic, logic, slt, r0, j and not-taken beq with single-cycle ack
    clear_mem();
    ack_dly = 0;
    mem[0] = enc_i(6'h08, 0, 1, 16'd5);
    mem[1] = enc_i(6'h08, 0, 2, 16'd7);
    mem[2] = enc_r(1, 2, 3, 6'h20);
    mem[3] = enc_i(6'h2B, 0, 3, 16'h80);
    mem[4] = enc_r(1, 2, 5, 6'h22);
    mem[5] = enc_i(6'h2B, 0, 5, 16'h84);
    mem[6] = enc_r(1, 2, 6, 6'h24);
    mem[7] = enc_r(1, 2, 7, 6'h25);
    mem[8] = enc_r(5, 1, 8, 6'h2A);
    mem[9] = enc_r(1, 5, 9, 6'h2A);
    mem[10] = enc_r(1, 2, 0, 6'h20);
    mem[11] = enc_i(6'h2B, 0, 6, 16'h88);
    mem[12] = enc_i(6'h2B, 0, 7, 16'h8C);
    mem[13] = enc_i(6'h2B, 0, 8, 16'h90);
    mem[14] = enc_i(6'h2B, 0, 9, 16'h94);
    mem[15] = enc_i(6'h2B, 0, 0, 16'h98);
    mem[16] = enc_j(26'd20);
    mem[17] = 32'hFC000000;
    mem[20] = enc_i(6'h04, 1, 2, 16'd5);
    mem[21] = 32'hFC000000;
    reset_hold();
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_pc", {22'd0, pc_o}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst16_pc", {24'd0, pc_o2}, 32'h20);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", {22'd0, mem_addr}, 32'd0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("a12_pc", {22'd0, pc_o}, 32'd12);
    check("a12_retired", retired, PERF ? 32'd3 : 32'd0);
    wait_halt(400, "a_halt");
    check("a_add", mem[32], 32'd12);
    check("a_sub", mem[33], 32'hFFFFFFFE);
    check("a_and", mem[34], 32'd5);
    check("a_or", mem[35], 32'd7);
    check("a_slt_neg", mem[36], 32'd1);
    check("a_slt_pos", mem[37], 32'd0);
    check("a_r0", mem[38], 32'd0);
    check("a_pc", {22'd0, pc_o}, 32'h54);
    check("a_retired", retired, PERF ? 32'd18 : 32'd0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || halted !== 1'b1) n++;
    end
    check("a_halt_idle", n, 32'd0);

    // store then load with a 3-cycle ack delay
    clear_mem();
    ack_dly = 3;
    mem[0] = enc_i(6'h08, 0, 3, 16'd12);
    mem[1] = enc_j(26'd8);
    mem[8] = enc_i(6'h2B, 0, 3, 16'd8);
    mem[9] = enc_i(6'h23, 0, 4, 16'd8);
    mem[10] = enc_i(6'h2B, 0, 4, 16'h40);
    mem[11] = 32'hFC000000;
    reset_hold();
    rst = 1'b0;
    wait_halt(400, "b_halt");
    check("b_nacc", log_q.size(), 32'd9);
    check("b_jfetch", {22'd0, log_q[2].a}, 32'h20);
    check("b_st_addr", {22'd0, log_q[3].a}, 32'd8);
    check("b_st_we", {31'd0, log_q[3].we}, 32'd1);
    check("b_st_data", log_q[3].d, 32'd12);
    check("b_st_len", log_q[3].len, 32'd4);
    check("b_ld_addr", {22'd0, log_q[5].a}, 32'd8);
    check("b_ld_we", {31'd0, log_q[5].we}, 32'd0);
    check("b_ld_len", log_q[5].len, 32'd4);
    check("b_lw_val", mem[16], 32'd12);
    check("b_pc", {22'd0, pc_o}, 32'h2C);

    // beq at 0x10: equal operands loop to 0x10 every 3 cycles, unequal fall to 0x14
    for (int run = 0; run < 2; run++) begin
      clear_mem();
      ack_dly = 0;
      mem[0] = enc_i(6'h08, 0, 1, 16'd3);
      mem[1] = enc_i(6'h08, 0, 2, run == 0 ? 16'd3 : 16'd4);
      mem[2] = enc_i(6'h08, 0, 0, 16'd0);
      mem[3] = enc_i(6'h08, 0, 0, 16'd0);
      mem[4] = enc_i(6'h04, 1, 2, 16'hFFFF);
      mem[5] = 32'hFC000000;
      reset_hold();
      rst = 1'b0;
      if (run == 0) begin
        repeat (40) @(negedge clk);
        check("c_loop1", {22'd0, log_q[5].a}, 32'h10);
        check("c_loop2", {22'd0, log_q[6].a}, 32'h10);
        check("c_beq_lat", log_q[6].t - log_q[5].t, 32'd3);
        check("c_nohalt", {31'd0, halted}, 32'd0);
      end else begin
        wait_halt(200, "c_halt");
        check("c_ne_pc", {22'd0, pc_o}, 32'h14);
      end
    end

    // illegal opcode 0x11 and illegal funct both halt without touching the bus
    for (int run = 0; run < 2; run++) begin
      clear_mem();
      mem[0] = run == 0 ? {6'h11, 26'd0} : enc_r(1, 2, 3, 6'h21);
      reset_hold();
      rst = 1'b0;
      wait_halt(20, "d_halt");
      n = 0;
      repeat (20) begin
        @(negedge clk);
        if (mem_req !== 1'b0) n++;
      end
      check("d_req_idle", n, 32'd0);
      check("d_retired", retired, 32'd0);
      reset_hold();
      check("d_rst_pc", {22'd0, pc_o}, 32'd0);
      check("d_rst_halted", {31'd0, halted}, 32'd0);
    end

    // reset in the middle of a fetch wait restarts from RESET_PC
    clear_mem();
    ack_dly = 2;
    mem[0] = enc_i(6'h08, 0, 1, 16'd5);
    mem[1] = enc_i(6'h2B, 0, 1, 16'h40);
    mem[2] = enc_i(6'h08, 1, 1, 16'd1);
    mem[3] = enc_i(6'h2B, 0, 1, 16'h44);
    mem[4] = 32'hFC000000;
    reset_hold();
    rst = 1'b0;
    n = 0;
    while (!(mem_req === 1'b1 && mem_addr === 10'd8 && mem_we === 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("e_reach_fetch8", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("e_rst_req", {31'd0, mem_req}, 32'd0);
    log_q.delete();
    mem[16] = 32'hDEADBEEF;
    rst = 1'b0;
    wait_halt(400, "e_halt");
    check("e_refetch", {22'd0, log_q[0].a}, 32'd0);
    check("e_st1", mem[16], 32'd5);
    check("e_st2", mem[17], 32'd6);

    // 16-bit datapath: wraparound and signed compare, RESET_PC = 0x20
    for (int i = 0; i < 64; i++) mem2[i] = (i >= 16) ? 32'hAAAA : 32'h0;
    mem2[8] = enc_i(6'h08, 0, 1, 16'h7FFF);
    mem2[9] = enc_i(6'h08, 1, 2, 16'd1);
    mem2[10] = enc_r(2, 2, 4, 6'h20);
    mem2[11] = enc_i(6'h2B, 0, 2, 16'h40);
    mem2[12] = enc_i(6'h2B, 0, 4, 16'h44);
    mem2[13] = enc_r(2, 1, 5, 6'h2A);
    mem2[14] = enc_i(6'h2B, 0, 5, 16'h48);
    mem2[15] = 32'hFC000000;
    @(negedge clk);
    rst2 = 1'b0;
    n = 0;
    while (halted2 !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("x16_halt", {31'd0, halted2}, 32'd1);
    check("x16_wrap", mem2[16], 32'h8000);
    check("x16_add_wrap", mem2[17], 32'h0);
    check("x16_slt", mem2[18], 32'h1);
    check("x16_pc", {24'd0, pc_o2}, 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
